// File: rtl/conv3x3_systolic_pkg.sv
// Shared widths and weight-unpack helper for the conv3x3_systolic engine.
package conv3x3_systolic_pkg;

  localparam int PIX_W       = 8;
  localparam int WGT_W       = 8;
  localparam int ACC_W       = 32;
  localparam int KERNEL_TAPS = 9;

  // k[r][c] sits at bits [8*(3r+c)+7 : 8*(3r+c)] of the flat kernel word.
  function automatic logic signed [WGT_W-1:0] unpack_weight(
    input logic [KERNEL_TAPS*WGT_W-1:0] flat,
    input int                           r,
    input int                           c
  );
    return flat[WGT_W*(3*r+c) +: WGT_W];
  endfunction

endpackage

// File: rtl/conv3x3_systolic_mac.sv
// Weight-stationary MAC cell: pixel moves east, partial sum moves south, one cycle each.
module conv3x3_systolic_mac
  import conv3x3_systolic_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic signed [WGT_W-1:0] in_weight,
  input  logic        [PIX_W-1:0] in_west,
  output logic        [PIX_W-1:0] out_east,
  input  logic signed [ACC_W-1:0] in_north,
  output logic signed [ACC_W-1:0] out_south
);

  logic signed [ACC_W-1:0] pix_ext;
  logic signed [ACC_W-1:0] wgt_ext;
  logic signed [ACC_W-1:0] product;

  // Pixels are unsigned: zero-extend; weights are signed: sign-extend.
  assign pix_ext = {{(ACC_W-PIX_W){1'b0}}, in_west};
  assign wgt_ext = {{(ACC_W-WGT_W){in_weight[WGT_W-1]}}, in_weight};
  assign product = pix_ext * wgt_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_east  <= '0;
      out_south <= '0;
    end else begin
      out_east  <= in_west;
      out_south <= in_north + product;
    end
  end

endmodule

// File: rtl/conv3x3_systolic.sv
// Streaming 3x3 convolution: line buffer + skew registers + 3x3 systolic MAC array.
// Optional CONV3X3_SYSTOLIC_DEBUG_EN adds a simulation-only per-result display.
module conv3x3_systolic
  import conv3x3_systolic_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  input  logic [DATA_WIDTH-1:0]        in_data,
  input  logic [KERNEL_TAPS*WGT_W-1:0] flat_weights,
  output logic signed [ACC_W-1:0]      out_pixel,
  output logic                         out_valid
);

  localparam int LB_LEN = 2*IMG_WIDTH + 1;

  logic [DATA_WIDTH-1:0]   lb [LB_LEN];
  logic [PIX_W-1:0]        skew_r1;
  logic [PIX_W-1:0]        skew_r2a;
  logic [PIX_W-1:0]        skew_r2b;
  logic [PIX_W-1:0]        west [3][3];
  logic [PIX_W-1:0]        east_unused [3];
  logic signed [ACC_W-1:0] psum [4][3];
  logic [4:0]              valid_sr;

  // Sample chain: lb[0] = S[n], lb[W] = S[n-W], lb[2W] = S[n-2W].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LB_LEN; i++) lb[i] <= '0;
      skew_r1  <= '0;
      skew_r2a <= '0;
      skew_r2b <= '0;
    end else if (in_valid) begin
      lb[0] <= in_data;
      for (int i = 1; i < LB_LEN; i++) lb[i] <= lb[i-1];
      skew_r1  <= lb[IMG_WIDTH];
      skew_r2a <= lb[0];
      skew_r2b <= skew_r2a;
    end
  end

  // Lower rows see their taps later so their pixels meet the partial sums arriving from above.
  assign west[0][0] = lb[2*IMG_WIDTH];
  assign west[1][0] = skew_r1;
  assign west[2][0] = skew_r2b;

  genvar r, c;
  generate
    for (c = 0; c < 3; c++) begin : g_top
      assign psum[0][c] = '0;
    end
    for (r = 0; r < 3; r++) begin : g_row
      for (c = 0; c < 3; c++) begin : g_col
        if (c < 2) begin : g_pass
          conv3x3_systolic_mac u_mac (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_weight (unpack_weight(flat_weights, r, c)),
            .in_west   (west[r][c]),
            .out_east  (west[r][c+1]),
            .in_north  (psum[r][c]),
            .out_south (psum[r+1][c])
          );
        end else begin : g_last
          conv3x3_systolic_mac u_mac (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_weight (unpack_weight(flat_weights, r, c)),
            .in_west   (west[r][c]),
            .out_east  (east_unused[r]),
            .in_north  (psum[r][c]),
            .out_south (psum[r+1][c])
          );
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_pixel <= '0;
      valid_sr  <= '0;
    end else begin
      out_pixel <= psum[3][0] + psum[3][1] + psum[3][2];
      valid_sr  <= {valid_sr[3:0], in_valid};
    end
  end

  assign out_valid = valid_sr[4];

`ifdef CONV3X3_SYSTOLIC_DEBUG_EN
  always @(posedge clk) begin
    if (out_valid)
      $display("conv3x3_systolic: out_pixel=%0d col0=%0d col1=%0d col2=%0d",
               out_pixel, psum[3][0], psum[3][1], psum[3][2]);
  end
`else
`endif

endmodule

// File: tb/tb_conv3x3_systolic.sv
// Scoreboard bench for conv3x3_systolic against a direct window-sum reference model.
module tb_conv3x3_systolic;

  localparam int W = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic [71:0] flat_weights = '0;
  logic [31:0] out_pixel;
  logic        out_valid;

  conv3x3_systolic #(.DATA_WIDTH(8), .IMG_WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .flat_weights (flat_weights),
    .out_pixel    (out_pixel),
    .out_valid    (out_valid)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic signed [7:0] wk [3][3];
  logic [31:0] exp_q[$];
  bit          chk_q[$];
  int          hist[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: sum over the 3x3 window taken straight from the sample history.
  function automatic logic [31:0] ref_out(input int n);
    int sum = 0;
    for (int rr = 0; rr < 3; rr++)
      for (int cc = 0; cc < 3; cc++) begin
        int m = n - cc - (2 - rr) * W;
        if (m >= 0) sum += int'(wk[rr][cc]) * hist[m];
      end
    return sum[31:0];
  endfunction

  task automatic apply_weights();
    for (int rr = 0; rr < 3; rr++)
      for (int cc = 0; cc < 3; cc++)
        flat_weights[8*(3*rr+cc) +: 8] = wk[rr][cc];
  endtask

  task automatic clear_weights();
    for (int rr = 0; rr < 3; rr++)
      for (int cc = 0; cc < 3; cc++)
        wk[rr][cc] = 8'sd0;
  endtask

  // Drivers
  task automatic cycle_drive(input bit v, input logic [7:0] px, input bit chk);
    @(posedge clk);
    #1;
    in_valid = v;
    in_data  = px;
    if (v) begin
      hist.push_back(int'(px));
      exp_q.push_back(ref_out(hist.size() - 1));
      chk_q.push_back(chk);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_out_pixel", out_pixel, 32'd0);
    hist.delete();
    exp_q.delete();
    chk_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // mode 0: ramp, 1: constant, 2: random. The tail is left unchecked since it abuts the stream end.
  task automatic run_burst(input int len, input int mode, input logic [7:0] cval);
    logic [7:0] px;
    for (int i = 0; i < len; i++) begin
      px = (mode == 0) ? i[7:0] : (mode == 1) ? cval : 8'($urandom_range(0, 255));
      cycle_drive(1'b1, px, i < len - 4);
    end
    cycle_drive(1'b0, 8'd0, 1'b0);
    repeat (7) @(posedge clk);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_out_valid: got out_valid=1 expected no pending result at %0t", $time);
      end else begin
        logic [31:0] e;
        bit          c;
        e = exp_q.pop_front();
        c = chk_q.pop_front();
        if (c) check("out_pixel", out_pixel, e);
      end
    end
  end

  initial begin
    clear_weights();
    apply_weights();
    do_reset();

    // Single pulse: out_valid only in cycle 5
    wk[2][0] = 8'sd3;
    apply_weights();
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = 8'd77;
    hist.push_back(77);
    exp_q.push_back(32'd0);
    chk_q.push_back(1'b0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check($sformatf("latency_cycle%0d", k), {31'd0, out_valid}, {31'd0, k == 5});
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end

    // Identity on k[2][0], ramp
    do_reset();
    clear_weights();
    wk[2][0] = 8'sd1;
    apply_weights();
    run_burst(40, 0, 8'd0);

    // Center tap, ramp
    do_reset();
    clear_weights();
    wk[1][1] = 8'sd1;
    apply_weights();
    run_burst(40, 0, 8'd0);

    // All-ones kernel, constant 5
    do_reset();
    for (int rr = 0; rr < 3; rr++)
      for (int cc = 0; cc < 3; cc++)
        wk[rr][cc] = 8'sd1;
    apply_weights();
    run_burst(30, 1, 8'd5);

    // Negative weight against max pixel: unsigned pixel extension
    do_reset();
    clear_weights();
    wk[2][0] = -8'sd1;
    apply_weights();
    run_burst(12, 1, 8'd255);

    // Random kernels and pixels
    for (int t = 0; t < 3; t++) begin
      do_reset();
      for (int rr = 0; rr < 3; rr++)
        for (int cc = 0; cc < 3; cc++)
          wk[rr][cc] = 8'($urandom_range(0, 255));
      apply_weights();
      run_burst(3 * W + 10, 2, 8'd0);
    end

    // Reset mid-stream with results still in flight
    do_reset();
    clear_weights();
    wk[2][0] = 8'sd1;
    wk[0][2] = 8'sd2;
    apply_weights();
    for (int i = 0; i < 10; i++) cycle_drive(1'b1, 8'd200, i < 6);
    do_reset();
    run_burst(30, 2, 8'd0);

    // Gappy valid pattern: out_valid count and order must track in_valid
    do_reset();
    for (int i = 0; i < 60; i++)
      cycle_drive(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'b0);
    cycle_drive(1'b0, 8'd0, 1'b0);
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
